// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- registered, parametrised sequential ALU for the TurtleMCU datapath
//
// Sits between register-file read and writeback. A request is taken with a
// valid/ready handshake, executed in one cycle (logic/arith/rotate ops) or
// iteratively (variable shifts, optional multiplier), and the result is
// presented with a second valid/ready handshake. The core stalls on
// in_ready / out_valid.
//
// Optional feature macro: ALU_MUL_EN
//   defined   -> op 12 (MUL) is a WIDTH-cycle unsigned shift-add multiplier
//   undefined -> no multiplier datapath; op 12 behaves as a reserved op
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (aborts any operation)
//   in_valid   request valid
//   in_ready   block can accept a request this cycle
//   op[3:0]    operation select
//   arg_a      operand A
//   arg_b      operand B (shift amount = arg_b[SHW-1:0])
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out        result
//   carry      carry/borrow of the completed op
//   zero       out == 0 for the completed op
//   neg        out[WIDTH-1] for the completed op
//   flag_c     sticky carry, carry-in for ADC/SBC
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] arg_a,
  input  logic [WIDTH-1:0] arg_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             flag_c
);

  // Shift-amount field width; derived from WIDTH, never overridden.
  localparam int SHW = $clog2(WIDTH);
  // Iteration counter must also hold WIDTH itself for the multiplier.
  localparam int CW  = SHW + 1;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_NOT  = 4'd4,
    OP_XOR  = 4'd5,
    OP_ROL1 = 4'd6,
    OP_ROR1 = 4'd7,
    OP_ADC  = 4'd8,
    OP_SBC  = 4'd9,
    OP_SHL  = 4'd10,
    OP_SHR  = 4'd11,
    OP_MUL  = 4'd12
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  // ------------------------------------------------------------------------
  // Request decode
  // ------------------------------------------------------------------------
  logic           accept;
  logic [SHW-1:0] amt;
  logic           is_shift;
  logic           is_mul;
  logic           multi;

  assign amt      = arg_b[SHW-1:0];
  assign is_shift = ((op == OP_SHL) || (op == OP_SHR)) && (amt != '0);

`ifdef ALU_MUL_EN
  assign is_mul = (op == OP_MUL);
`else
  assign is_mul = 1'b0;
`endif

  // Ops that go through BUSY; everything else lands in DONE directly.
  assign multi  = is_shift | is_mul;
  assign accept = in_valid & in_ready;

  // ------------------------------------------------------------------------
  // Single-cycle ALU, evaluated on the request operands. ADC/SBC take the
  // sticky flag_c as it stands at the accept edge, which in DONE is the
  // carry of the result being consumed.
  // ------------------------------------------------------------------------
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;

  // NOTE: every signal assigned in a combinational block gets a default first,
  // so no path through the case statement can leave it unassigned (latch).
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      OP_ADD:  {alu_c, alu_res} = {1'b0, arg_a} + {1'b0, arg_b};
      // Bit WIDTH of the (WIDTH+1)-bit difference is the borrow (B > A).
      OP_SUB:  {alu_c, alu_res} = {1'b0, arg_a} - {1'b0, arg_b};
      OP_AND:  alu_res = arg_a & arg_b;
      OP_OR:   alu_res = arg_a | arg_b;
      OP_NOT:  alu_res = ~arg_a;
      OP_XOR:  alu_res = arg_a ^ arg_b;
      OP_ROL1: begin
        alu_res = {arg_a[WIDTH-2:0], arg_a[WIDTH-1]};
        alu_c   = arg_a[WIDTH-1];
      end
      OP_ROR1: begin
        alu_res = {arg_a[0], arg_a[WIDTH-1:1]};
        alu_c   = arg_a[0];
      end
      OP_ADC:  {alu_c, alu_res} = {1'b0, arg_a} + {1'b0, arg_b}
                                  + {{WIDTH{1'b0}}, flag_c};
      // Borrow out of the WIDTH+1 subtraction equals (B + flag_c) > A.
      OP_SBC:  {alu_c, alu_res} = {1'b0, arg_a} - {1'b0, arg_b}
                                  - {{WIDTH{1'b0}}, flag_c};
      // Only reached here for a zero shift amount: pass A, no carry.
      OP_SHL,
      OP_SHR:  alu_res = arg_a;
      // Reserved ops (and MUL when the multiplier is not built).
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Iterative datapath (BUSY)
  // ------------------------------------------------------------------------
  logic [3:0]       op_q;     // op of the in-flight multi-cycle request
  logic [CW-1:0]    cnt_q;    // iterations remaining, including this one
  logic [WIDTH-1:0] sh_q;     // shift working register
  logic [WIDTH-1:0] sh_next;
  logic             sh_bit;   // bit leaving sh_q this iteration
  logic             last_step;
  logic [WIDTH-1:0] step_res;
  logic             step_c;

  assign last_step = (cnt_q == CW'(1));

  always_comb begin
    if (op_q == OP_SHL) begin
      sh_next = {sh_q[WIDTH-2:0], 1'b0};
      sh_bit  = sh_q[WIDTH-1];
    end else begin
      sh_next = {1'b0, sh_q[WIDTH-1:1]};
      sh_bit  = sh_q[0];
    end
  end

`ifdef ALU_MUL_EN
  // Shift-add multiplier: prod_q starts as {0, B}; each step adds A into the
  // upper half when the current LSB is set, then shifts the whole product
  // right by one. After WIDTH steps prod_q holds A*B.
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH:0]     prod_sum;

  always_comb begin
    prod_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
              + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    prod_next = {prod_sum, prod_q[WIDTH-1:1]};
  end
`endif

  always_comb begin
    step_res = sh_next;
    step_c   = sh_bit;
`ifdef ALU_MUL_EN
    if (op_q == OP_MUL) begin
      step_res = prod_next[WIDTH-1:0];
      step_c   = |prod_next[2*WIDTH-1:WIDTH];
    end
`endif
  end

  // ------------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs as they were before the edge, whatever the block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = multi ? S_BUSY : S_DONE;
      end
      S_BUSY: begin
        if (last_step) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        // Consuming the result frees the block, so a new request can be
        // taken in the same cycle.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) state_d = multi ? S_BUSY : S_DONE;
          else          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // Result selection: flags change only on entry to DONE.
  // ------------------------------------------------------------------------
  logic             load_res;
  logic [WIDTH-1:0] res_val;
  logic             res_c;

  always_comb begin
    load_res = 1'b0;
    res_val  = alu_res;
    res_c    = alu_c;
    if (accept && !multi) begin
      load_res = 1'b1;
    end else if ((state_q == S_BUSY) && last_step) begin
      load_res = 1'b1;
      res_val  = step_res;
      res_c    = step_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out    <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      flag_c <= 1'b0;
    end else if (load_res) begin
      out    <= res_val;
      carry  <= res_c;
      zero   <= (res_val == '0);
      neg    <= res_val[WIDTH-1];
      flag_c <= res_c;
    end
  end

  // ------------------------------------------------------------------------
  // Iteration registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      cnt_q <= '0;
      sh_q  <= '0;
    end else if (accept && multi) begin
      op_q  <= op;
      cnt_q <= is_mul ? CW'(WIDTH) : CW'(amt);
      sh_q  <= arg_a;
    end else if (state_q == S_BUSY) begin
      cnt_q <= cnt_q - CW'(1);
      sh_q  <= sh_next;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q <= '0;
      prod_q  <= '0;
    end else if (accept && is_mul) begin
      mcand_q <= arg_a;
      prod_q  <= {{WIDTH{1'b0}}, arg_b};
    end else if (state_q == S_BUSY) begin
      prod_q  <= prod_next;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH = 8)
//
// A directed sequence pins literal results, latencies and the reset/abort
// behaviour; a randomized phase then drives random requests and random
// backpressure. An independent compare process predicts, every cycle, the
// handshake outputs and the held result from an arithmetic model of the ops.
// Honours ALU_MUL_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  localparam int W = 8;

  localparam logic [3:0] ADD = 4'd0,  SUB = 4'd1,  AND_ = 4'd2, OR_ = 4'd3;
  localparam logic [3:0] NOT_ = 4'd4, XOR_ = 4'd5, ROL1 = 4'd6, ROR1 = 4'd7;
  localparam logic [3:0] ADC = 4'd8,  SBC = 4'd9,  SHL = 4'd10, SHR = 4'd11;
  localparam logic [3:0] MUL = 4'd12;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] arg_a;
  logic [W-1:0] arg_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         carry;
  logic         zero;
  logic         neg;
  logic         flag_c;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .arg_a     (arg_a),
    .arg_b     (arg_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carry     (carry),
    .zero      (zero),
    .neg       (neg),
    .flag_c    (flag_c)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: result, carry and latency (cycles from accept to out_valid)
  // straight from the op definitions, using plain integer arithmetic.
  function automatic void model(input logic [3:0] o, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic fc,
                                output logic [W-1:0] r, output logic c,
                                output int lat);
    int unsigned ua, ub, uf, amt, full;
    longint unsigned p;
    ua = a; ub = b; uf = fc; amt = ub % W;
    full = 0; r = '0; c = 1'b0; lat = 1;
    case (o)
      ADD:  begin full = ua + ub;      r = W'(full); c = full >= (1 << W); end
      SUB:  begin r = W'(ua - ub);     c = ub > ua; end
      AND_: r = a & b;
      OR_:  r = a | b;
      NOT_: r = ~a;
      XOR_: r = a ^ b;
      ROL1: begin r = W'((ua << 1) | (ua >> (W - 1))); c = ((ua >> (W - 1)) & 1) != 0; end
      ROR1: begin r = W'((ua >> 1) | ((ua & 1) << (W - 1))); c = (ua & 1) != 0; end
      ADC:  begin full = ua + ub + uf; r = W'(full); c = full >= (1 << W); end
      SBC:  begin r = W'(ua - ub - uf); c = (ub + uf) > ua; end
      SHL:  begin
        r = W'(ua << amt);
        c = (amt != 0) && (((ua >> (W - amt)) & 1) != 0);
        lat = amt + 1;
      end
      SHR:  begin
        r = W'(ua >> amt);
        c = (amt != 0) && (((ua >> (amt - 1)) & 1) != 0);
        lat = amt + 1;
      end
`ifdef ALU_MUL_EN
      MUL:  begin
        p = longint'(ua) * longint'(ub);
        r = W'(p);
        c = (p >> W) != 0;
        lat = W + 1;
      end
`endif
      default: begin r = '0; c = 1'b0; end
    endcase
  endfunction

  task automatic pin(input string name, input logic [3:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic fc, input logic [W-1:0] er,
                     input logic ec, input int elat);
    logic [W-1:0] r;
    logic         c;
    int           lat;
    model(o, a, b, fc, r, c, lat);
    check({name, "_res"}, r, er);
    check({name, "_c"}, c, ec);
    check({name, "_lat"}, lat, elat);
  endtask

  // ------------------------------------------------------------------------
  // Compare process: predicts the DUT every cycle at the falling edge and
  // advances its own transaction state for the following rising edge.
  // ------------------------------------------------------------------------
  initial begin : compare
    bit           have;
    int           w;
    int           lat_m;
    logic [W-1:0] eo;
    logic         ec;
    logic         fc;
    bit           ev;
    bit           eir;
    have = 0; w = 0; lat_m = 1; eo = '0; ec = 1'b0; fc = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        have = 0;
        fc   = 1'b0;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out", out, '0);
        check("rst_carry", carry, 1'b0);
        check("rst_zero", zero, 1'b0);
        check("rst_neg", neg, 1'b0);
        check("rst_flag_c", flag_c, 1'b0);
      end else begin
        ev = have && (w >= lat_m);
        if (ev) fc = ec;
        eir = !have ? 1'b1 : (ev ? out_ready : 1'b0);
        check("cmp_out_valid", out_valid, ev);
        check("cmp_in_ready", in_ready, eir);
        check("cmp_flag_c", flag_c, fc);
        if (ev) begin
          check("cmp_out", out, eo);
          check("cmp_carry", carry, ec);
          check("cmp_zero", zero, eo == '0);
          check("cmp_neg", neg, eo[W-1]);
        end
        if (ev && out_ready) have = 0;
        if (in_valid && eir) begin
          model(op, arg_a, arg_b, fc, eo, ec, lat_m);
          have = 1;
          w    = 0;
        end
        if (have) w++;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Driver
  // ------------------------------------------------------------------------
  task automatic drive(input logic v, input logic [3:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    in_valid = v; op = o; arg_a = a; arg_b = b;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // Called just after the accept edge; returns the cycle count to out_valid
  // or -1 if it never arrives within the budget.
  task automatic wait_valid(input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        return;
      end
      check("busy_in_ready", in_ready, 1'b0);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lat;
    rst = 1'b1;
    drive(1'b0, ADD, '0, '0);
    out_ready = 1'b1;

    // Model pins: hand-computed expectations.
    pin("m_add", ADD, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1);
    pin("m_sbc", SBC, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1);
    pin("m_shr", SHR, 8'h81, 8'h03, 1'b0, 8'h10, 1'b0, 4);
    pin("m_shl", SHL, 8'h81, 8'h01, 1'b0, 8'h02, 1'b1, 2);
    pin("m_ror", ROR1, 8'h01, 8'h00, 1'b0, 8'h80, 1'b1, 1);
`ifdef ALU_MUL_EN
    pin("m_mul", MUL, 8'h10, 8'h20, 1'b0, 8'h00, 1'b1, 9);
`else
    pin("m_mul", MUL, 8'h10, 8'h20, 1'b0, 8'h00, 1'b0, 1);
`endif

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    next_edge();

    // ADD -> ADC back-to-back -> SBC
    drive(1'b1, ADD, 8'hF0, 8'h20);
    next_edge();
    drive(1'b1, ADC, 8'h01, 8'h01);
    @(negedge clk);
    check("add_valid", out_valid, 1'b1);
    check("add_out", out, 8'h10);
    check("add_carry", carry, 1'b1);
    check("add_zero", zero, 1'b0);
    check("add_flag_c", flag_c, 1'b1);
    next_edge();
    drive(1'b1, SBC, 8'h00, 8'h00);
    @(negedge clk);
    check("adc_valid", out_valid, 1'b1);
    check("adc_out", out, 8'h03);
    check("adc_carry", carry, 1'b0);
    next_edge();
    drive(1'b0, ADD, '0, '0);
    @(negedge clk);
    check("sbc_out", out, 8'h00);
    check("sbc_zero", zero, 1'b1);
    check("sbc_carry", carry, 1'b0);
    next_edge();

    // Multi-cycle shift and zero-amount shift
    drive(1'b1, SHL, 8'h81, 8'h03);
    next_edge();
    drive(1'b0, ADD, '0, '0);
    wait_valid(40, lat);
    check("shl_lat", lat, 4);
    check("shl_out", out, 8'h08);
    check("shl_carry", carry, 1'b0);
    next_edge();
    drive(1'b1, SHR, 8'h81, 8'h00);
    next_edge();
    drive(1'b0, ADD, '0, '0);
    wait_valid(40, lat);
    check("shr0_lat", lat, 1);
    check("shr0_out", out, 8'h81);
    check("shr0_carry", carry, 1'b0);
    next_edge();

    // Multiply (or reserved)
    drive(1'b1, MUL, 8'h10, 8'h20);
    next_edge();
    drive(1'b0, ADD, '0, '0);
    wait_valid(40, lat);
`ifdef ALU_MUL_EN
    check("mul_lat", lat, 9);
    check("mul_carry", carry, 1'b1);
`else
    check("mul_lat", lat, 1);
    check("mul_carry", carry, 1'b0);
`endif
    check("mul_out", out, 8'h00);
    check("mul_zero", zero, 1'b1);
    next_edge();

    // Backpressure: result held while out_ready is low
    out_ready = 1'b0;
    drive(1'b1, SUB, 8'h05, 8'h07);
    next_edge();
    drive(1'b0, ADD, '0, '0);
    wait_valid(40, lat);
    check("sub_lat", lat, 1);
    for (int i = 0; i < 5; i++) begin
      next_edge();
      @(negedge clk);
      check("bp_valid", out_valid, 1'b1);
      check("bp_out", out, 8'hFE);
      check("bp_carry", carry, 1'b1);
      check("bp_neg", neg, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
    end
    next_edge();
    out_ready = 1'b1;
    #1 check("bp_release_in_ready", in_ready, 1'b1);
    next_edge();

    // Reset during a multiply aborts it
    drive(1'b1, MUL, 8'h10, 8'h20);
    next_edge();
    drive(1'b0, ADD, '0, '0);
    next_edge();
    next_edge();
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_flag_c", flag_c, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    next_edge();
    next_edge();
    rst = 1'b0;
    next_edge();
    drive(1'b1, ADD, 8'h01, 8'h02);
    next_edge();
    drive(1'b0, ADD, '0, '0);
    wait_valid(40, lat);
    check("post_rst_lat", lat, 1);
    check("post_rst_out", out, 8'h03);
    check("post_rst_carry", carry, 1'b0);
    next_edge();

    // Randomized traffic with random backpressure and corner operands
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = 4'($urandom_range(0, 15));
      arg_a     = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 8'hFF : 8'h00)
                                              : 8'($urandom);
      arg_b     = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 8'hFF : 8'h01)
                                              : 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      next_edge();
    end
    drive(1'b0, ADD, '0, '0);
    out_ready = 1'b1;
    repeat (20) next_edge();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered ALU that succeeds the fixed 8-bit combinational ALU in the TurtleMCU datapath.
- Adds operand width parameter, carry-chained ADC/SBC, variable-amount multi-cycle shifts and an optional iterative multiplier.
- Transactions use valid/ready handshakes on both sides.
- Sits between the register file read stage and the writeback stage; the core stalls on in_ready/out_valid.

Parameters:
WIDTH, 8, operand/result width in bits (>=4, power of two)
SHW, $clog2(WIDTH), shift-amount field width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operation request valid
in_ready  output  1  block can accept a request this cycle
op  input  4  operation select (encoding below)
arg_a  input  WIDTH  operand A
arg_b  input  WIDTH  operand B (shift amount = arg_b[SHW-1:0])
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out  output  WIDTH  result
carry  output  1  carry/borrow flag of the completed op
zero  output  1  out == 0 for the completed op
neg  output  1  out[WIDTH-1] for the completed op
flag_c  output  1  sticky carry register; used as carry-in for ADC/SBC

Behaviour:
- Reset: all outputs are 0 except in_ready, which is 1. State is IDLE. Reset asserted mid-operation aborts the operation; no result is produced.
- op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT(A), 5 XOR, 6 ROL1, 7 ROR1, 8 ADC, 9 SBC, 10 SHL, 11 SHR, 12 MUL, 13-15 reserved.
- Handshake:
  - Request accepted when in_valid & in_ready; op/arg_a/arg_b are captured that edge.
  - The result is held stable while out_valid & !out_ready.
  - The result is consumed when out_valid & out_ready.
- State machine:
  - IDLE: in_ready=1. On accept, go to BUSY for multi-cycle ops (SHL/SHR with amount>0, MUL); otherwise go to DONE.
  - BUSY: in_ready=0. Step one iteration per cycle; on the last iteration, go to DONE.
  - DONE: out_valid=1. in_ready = out_ready, so back-to-back issue is allowed. If out_ready & in_valid, accept the new request in the same edge. If out_ready & !in_valid, go to IDLE.
- Latency: out_valid rises 1 cycle after accept for single-cycle ops, amount+1 cycles for SHL/SHR, WIDTH+1 cycles for MUL.
- Arithmetic (results are mod 2^WIDTH):
  - ADD: carry = bit WIDTH of A+B.
  - SUB: carry(borrow) = B > A.
  - ADC: A+B+flag_c; carry = bit WIDTH.
  - SBC: A-B-flag_c; borrow = (B+flag_c) > A, computed at WIDTH+1 bits.
  - AND/OR/XOR/NOT: carry = 0.
  - ROL1: carry = A[WIDTH-1]. ROR1: carry = A[0].
  - SHL/SHR (logical, zero fill): one bit per cycle. Carry = last bit shifted out; amount 0 gives out=A, carry=0.
  - MUL: unsigned shift-add over WIDTH cycles; out = low WIDTH bits; carry = (high WIDTH bits != 0).
  - Reserved ops: out=0, carry=0, single-cycle.
- Flags: zero and neg are always derived from out. carry, zero and neg update only when entering DONE. flag_c loads carry at the same edge and otherwise holds, including across IDLE.
- ADC/SBC sample flag_c at accept time. A back-to-back accept in DONE therefore uses the flag_c of the result being consumed.

Optional Feature:
ALU_MUL_EN
- Defined: MUL (op 12) is implemented as above.
- Undefined: the multiplier datapath is absent. Op 12 behaves as a reserved op (out=0, carry=0, zero=1, 1-cycle latency), and BUSY is entered only for shifts.

Test Plan:
- WIDTH=8, ADD A=0xF0 B=0x20, out_ready=1 -> out_valid 1 cycle after accept; out=0x10, carry=1, zero=0, flag_c=1.
- Follow immediately with ADC A=0x01 B=0x01 issued back-to-back in DONE -> out=0x03, carry=0; then SBC A=0x00 B=0x00 with flag_c=0 -> out=0x00, zero=1, carry=0.
- SHL A=0x81 B=0x03 -> out_valid 4 cycles after accept, in_ready=0 while BUSY; out=0x08, carry=0. SHR A=0x81 B=0x00 -> 1 cycle, out=0x81, carry=0.
- MUL A=0x10 B=0x20 with ALU_MUL_EN -> out_valid 9 cycles after accept; out=0x00, carry=1, zero=1. Without the macro -> 1 cycle, out=0x00, carry=0.
- Backpressure: SUB A=0x05 B=0x07 with out_ready=0 for 5 cycles -> out=0xFE, carry=1, neg=1 held stable; in_ready=0 until out_ready rises.
- Assert rst during MUL cycle 3 -> out_valid=0, flag_c=0, in_ready=1 immediately; a new ADD issued after rst releases completes normally.
